// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage types: bus request/response structs, FSM states, reset PC.
package fetch_stage_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam addr_t RESET_PC_DEFAULT = 32'hbfc0_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction bus request/response bundle between fetch and memory.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;

    modport master (output ireq, input iresp);
    modport slave  (input ireq, output iresp);

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - fetch PC register with sequential/redirect next-PC selection.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  redirect,
    input  addr_t target,
    output addr_t pc,
    output addr_t pc_plus4
);

    // Sequential increment wraps naturally modulo 2^32.
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (en) begin
            pc <= redirect ? target : pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, ibus handshake, one-entry instruction buffer.
// Optional FETCH_ADDR_CHECK_EN: misaligned PC raises AdelF instead of issuing a bus request.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  StallF,
    input  logic  PCSrcD,
    input  addr_t PCBranchD,
    fetch_stage_if.master ibus,
    output addr_t PCF,
    output addr_t PCPlus4F,
    output word_t InstrF,
    output logic  InstrValidF,
    output logic  IStallF
`ifdef FETCH_ADDR_CHECK_EN
    ,
    output logic  AdelF
`endif
);

    fetch_state_t state, state_next;
    word_t        instr_q, instr_next;
    logic         adel_q, adel_next;
    logic         req_valid;
    logic         misaligned;
    ibus_req_t    req;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .en       ((state == HOLD) && !StallF),
        .redirect (PCSrcD),
        .target   (PCBranchD),
        .pc       (PCF),
        .pc_plus4 (PCPlus4F)
    );

`ifdef FETCH_ADDR_CHECK_EN
    assign misaligned = (PCF[1:0] != 2'b00);
    assign AdelF      = (state == HOLD) && adel_q;
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= REQ;
            instr_q <= '0;
            adel_q  <= 1'b0;
        end else begin
            state   <= state_next;
            instr_q <= instr_next;
            adel_q  <= adel_next;
        end
    end

    always_comb begin
        state_next = state;
        instr_next = instr_q;
        adel_next  = adel_q;
        req_valid  = 1'b0;
        case (state)
            REQ: begin
                if (misaligned) begin
                    state_next = HOLD;
                    instr_next = '0;
                    adel_next  = 1'b1;
                end else begin
                    req_valid = 1'b1;
                    // A data_ok without addr_ok belongs to no request of ours and is dropped.
                    if (ibus.iresp.addr_ok) begin
                        if (ibus.iresp.data_ok) begin
                            state_next = HOLD;
                            instr_next = ibus.iresp.data;
                            adel_next  = 1'b0;
                        end else begin
                            state_next = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (ibus.iresp.data_ok) begin
                    state_next = HOLD;
                    instr_next = ibus.iresp.data;
                    adel_next  = 1'b0;
                end
            end
            HOLD: begin
                if (!StallF) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // Request is suppressed during the reset cycle so memory never sees a request from stale state.
    always_comb begin
        req.valid = req_valid && !reset;
        req.addr  = PCF;
    end
    assign ibus.ireq = req;

    assign InstrValidF = (state == HOLD);
    assign InstrF      = InstrValidF ? instr_q : '0;
    assign IStallF     = (state != HOLD) || reset;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with transaction-level reference model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic  clk = 1'b0;
    always #5 clk = ~clk;

    logic  reset, StallF, PCSrcD;
    addr_t PCBranchD, PCF, PCPlus4F;
    word_t InstrF;
    logic  InstrValidF, IStallF;
`ifdef FETCH_ADDR_CHECK_EN
    logic  AdelF;
`endif

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'hbfc0_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .StallF      (StallF),
        .PCSrcD      (PCSrcD),
        .PCBranchD   (PCBranchD),
        .ibus        (bus),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .InstrF      (InstrF),
        .InstrValidF (InstrValidF),
        .IStallF     (IStallF)
`ifdef FETCH_ADDR_CHECK_EN
        ,
        .AdelF       (AdelF)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one instruction slot, tracked as "address accepted" / "instruction held".
    addr_t m_pc = 32'hbfc0_0000;
    word_t m_instr = '0;
    logic  m_known = 1'b0;
    logic  m_have = 1'b0;
    logic  m_taken = 1'b0;
    logic  m_adel = 1'b0;

    function automatic logic m_misaligned(input addr_t pc);
`ifdef FETCH_ADDR_CHECK_EN
        return pc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        logic req_exp;
        req_exp = !m_have && !m_taken && !m_misaligned(m_pc);
        if (reset) begin
            check1("rst_req_valid", bus.ireq.valid, 1'b0);
            check1("rst_istall", IStallF, 1'b1);
        end else if (m_known) begin
            check1("m_instr_valid", InstrValidF, m_have);
            check1("m_istall", IStallF, !m_have);
            check("m_pcf", PCF, m_pc);
            check("m_pcplus4", PCPlus4F, m_pc + 32'd4);
            check("m_instr", InstrF, m_have ? m_instr : 32'd0);
            check1("m_req_valid", bus.ireq.valid, req_exp);
            if (req_exp) check("m_req_addr", bus.ireq.addr, m_pc);
`ifdef FETCH_ADDR_CHECK_EN
            check1("m_adel", AdelF, m_have && m_adel);
`endif
        end

        if (reset) begin
            m_known = 1'b1;
            m_pc    = 32'hbfc0_0000;
            m_have  = 1'b0;
            m_taken = 1'b0;
            m_adel  = 1'b0;
            m_instr = '0;
        end else if (m_known) begin
            if (m_have) begin
                if (!StallF) begin
                    m_pc   = PCSrcD ? PCBranchD : m_pc + 32'd4;
                    m_have = 1'b0;
                end
            end else if (!m_taken && m_misaligned(m_pc)) begin
                m_have  = 1'b1;
                m_instr = '0;
                m_adel  = 1'b1;
            end else if (!m_taken) begin
                if (bus.iresp.addr_ok) begin
                    if (bus.iresp.data_ok) begin
                        m_have  = 1'b1;
                        m_instr = bus.iresp.data;
                        m_adel  = 1'b0;
                    end else begin
                        m_taken = 1'b1;
                    end
                end
            end else if (bus.iresp.data_ok) begin
                m_have  = 1'b1;
                m_taken = 1'b0;
                m_instr = bus.iresp.data;
                m_adel  = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic a, input logic d, input word_t w);
        bus.iresp = '{addr_ok: a, data_ok: d, data: w};
    endtask

    initial begin
        reset     = 1'b1;
        StallF    = 1'b0;
        PCSrcD    = 1'b0;
        PCBranchD = '0;
        resp(1'b0, 1'b0, '0);

        step();
        check("reset_pcf", PCF, 32'hbfc0_0000);
        check1("reset_instr_valid", InstrValidF, 1'b0);
        check1("reset_istall", IStallF, 1'b1);
        check1("reset_req_valid", bus.ireq.valid, 1'b0);
        check("reset_instr", InstrF, 32'h0);
        step();
        reset = 1'b0;
        #1;

        // Zero-wait memory: addr_ok and data_ok together.
        check1("t1_req_valid", bus.ireq.valid, 1'b1);
        check("t1_req_addr", bus.ireq.addr, 32'hbfc0_0000);
        resp(1'b1, 1'b1, 32'h2408_0001);
        step();
        resp(1'b0, 1'b0, '0);
        check1("t1_instr_valid", InstrValidF, 1'b1);
        check("t1_pcf", PCF, 32'hbfc0_0000);
        check("t1_instr", InstrF, 32'h2408_0001);
        check("t1_pcplus4", PCPlus4F, 32'hbfc0_0004);
        step();
        check("t2_req_addr", bus.ireq.addr, 32'hbfc0_0004);

        // Split transaction: data returns three cycles after addr_ok.
        resp(1'b1, 1'b0, '0);
        step();
        resp(1'b0, 1'b0, '0);
        check1("t2_wait_req_valid", bus.ireq.valid, 1'b0);
        check1("t2_wait_istall", IStallF, 1'b1);
        step();
        check1("t2_wait_istall2", IStallF, 1'b1);
        step();
        check1("t2_wait_istall3", IStallF, 1'b1);
        resp(1'b0, 1'b1, 32'h8c09_0010);
        StallF = 1'b1;
        step();
        resp(1'b0, 1'b0, '0);
        check("t2_instr", InstrF, 32'h8c09_0010);
        check("t2_pcf", PCF, 32'hbfc0_0004);
        check1("t2_istall", IStallF, 1'b0);

        // Stalled HOLD keeps everything still.
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_hold_pcf", PCF, 32'hbfc0_0004);
            check("t3_hold_instr", InstrF, 32'h8c09_0010);
            check1("t3_hold_req_valid", bus.ireq.valid, 1'b0);
        end
        StallF = 1'b0;
        step();
        check1("t3_next_req_valid", bus.ireq.valid, 1'b1);
        check("t3_next_req_addr", bus.ireq.addr, 32'hbfc0_0008);

        // Branch redirect taken at HOLD->REQ.
        resp(1'b1, 1'b1, 32'h1000_0003);
        step();
        resp(1'b0, 1'b0, '0);
        PCSrcD    = 1'b1;
        PCBranchD = 32'hbfc0_0100;
        step();
        PCSrcD = 1'b0;
        check("t4_req_addr", bus.ireq.addr, 32'hbfc0_0100);
        check("t4_pcf", PCF, 32'hbfc0_0100);

        // addr_ok withheld; a stray data_ok in the middle must be ignored.
        for (int i = 0; i < 5; i++) begin
            check1("t5_req_valid", bus.ireq.valid, 1'b1);
            check("t5_req_addr", bus.ireq.addr, 32'hbfc0_0100);
            if (i == 2) resp(1'b0, 1'b1, 32'hdead_beef);
            step();
            resp(1'b0, 1'b0, '0);
        end
        check1("t5_no_capture", InstrValidF, 1'b0);
        resp(1'b1, 1'b0, '0);
        step();
        resp(1'b0, 1'b0, '0);
        check1("t5_wait_req_valid", bus.ireq.valid, 1'b0);

        // Reset while waiting for data, then a stale data_ok.
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("t5_rst_pcf", PCF, 32'hbfc0_0000);
        check1("t5_rst_req_valid", bus.ireq.valid, 1'b1);
        check("t5_rst_req_addr", bus.ireq.addr, 32'hbfc0_0000);
        resp(1'b0, 1'b1, 32'hbad0_bad0);
        step();
        resp(1'b0, 1'b0, '0);
        check1("t5_stale_valid", InstrValidF, 1'b0);
        check1("t5_stale_istall", IStallF, 1'b1);

        // PC wrap at the top of the address space; PCSrcD ignored outside HOLD.
        resp(1'b1, 1'b1, 32'h0000_0004);
        step();
        resp(1'b0, 1'b0, '0);
        check("t6_instr", InstrF, 32'h0000_0004);
        PCSrcD    = 1'b1;
        PCBranchD = 32'hffff_fffc;
        step();
        check("t6_req_addr", bus.ireq.addr, 32'hffff_fffc);
        check("t6_pcplus4_wrap", PCPlus4F, 32'h0000_0000);
        PCBranchD = 32'h1234_5670;
        resp(1'b1, 1'b1, 32'h0000_0005);
        step();
        resp(1'b0, 1'b0, '0);
        PCSrcD = 1'b0;
        check("t6_pcf", PCF, 32'hffff_fffc);
        check("t6_instr2", InstrF, 32'h0000_0005);
        step();
        check("t6_wrap_req_addr", bus.ireq.addr, 32'h0000_0000);
        check("t6_wrap_pcf", PCF, 32'h0000_0000);

        // Misaligned redirect target.
        resp(1'b1, 1'b1, 32'h0000_0006);
        step();
        resp(1'b0, 1'b0, '0);
        PCSrcD    = 1'b1;
        PCBranchD = 32'hbfc0_0102;
        step();
        PCSrcD = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
        check1("t7_no_req", bus.ireq.valid, 1'b0);
        step();
        check1("t7_adel", AdelF, 1'b1);
        check("t7_instr", InstrF, 32'h0);
        check1("t7_instr_valid", InstrValidF, 1'b1);
        check1("t7_istall", IStallF, 1'b0);
`else
        check1("t7_req_valid", bus.ireq.valid, 1'b1);
        check("t7_req_addr", bus.ireq.addr, 32'hbfc0_0102);
        resp(1'b1, 1'b1, 32'h0000_0007);
        step();
        resp(1'b0, 1'b0, '0);
        check("t7_instr", InstrF, 32'h0000_0007);
        check("t7_pcf", PCF, 32'hbfc0_0102);
`endif
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
